dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of the 16-bit data memory (1024 words, write on clk-low half, combinational read).
- Port 0 is the CPU load/store path; port 1 is the loader/debug DMA path.
- Round-robin arbitration, one access outstanding at a time.
- Memory command signals are registered for one full ACCESS cycle; read data is captured at the end of that cycle.

Parameters:
- DW, 16, data width
- AW, 16, address width
- DEPTH, 1024, implemented words; addresses >= DEPTH are out of range

Ports:
- clk  in  1  clock, rising edge
- reset_n  in  1  synchronous active-low reset
- req0  in  1  port 0 request; held stable with we0/addr0/wdata0 until gnt0
- we0  in  1  1 = write, 0 = read
- addr0  in  AW  port 0 word address
- wdata0  in  DW  port 0 write data
- gnt0  out  1  one-cycle pulse: request accepted
- rvalid0  out  1  one-cycle pulse: access complete (reads and writes)
- rdata0  out  DW  read data, valid with rvalid0
- err0  out  1  with rvalid0: address out of range
- req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1, err1: same for port 1
- mem_addr  out  AW  to memory addr
- mem_wdata  out  DW  to memory Write_data
- mem_read  out  1  to memory MemRead
- mem_write  out  1  to memory MemWrite
- mem_rdata  in  DW  from memory Read_data
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - State goes to IDLE; last_grant = 1, so port 0 wins the first tie.
  - All outputs are 0: gnt*, rvalid*, rdata*, err*, mem_*, busy.
- States:
  - IDLE: arbitrate. On any request, pulse gnt for the winner, latch port id, we, addr and wdata, and go to ACCESS.
  - ACCESS: one cycle. mem_addr, mem_wdata, mem_read = ~we and mem_write = we are driven from registers.
    - Memory writes during the clk-low half of this cycle.
    - At the closing edge: capture mem_rdata into the winner's rdata (reads only), then go to DONE.
  - DONE: pulse rvalid and err for the winner; mem_read = mem_write = 0. Arbitrate again in the same cycle: a request goes to ACCESS, otherwise to IDLE.
- Latency: request seen at edge N → gnt high in cycle N, ACCESS in N+1, rvalid in N+2. Best-case throughput is one access every 2 cycles.
- Arbitration:
  - Only one requester → it wins.
  - Both requesting → the port != last_grant wins.
  - last_grant updates on every grant.
- Out of range (addr >= DEPTH):
  - gnt is still issued and ACCESS is still entered, but mem_read and mem_write are held at 0.
  - In DONE: rdata = 0, err = 1.
- Write response: rdata for the port is left unchanged and err = 0 (if in range).
- The non-winning port's rvalid, rdata and err are not disturbed.
- Requester protocol:
  - Requester deasserts req the cycle after gnt, or keeps it high to queue a new request.
  - Dropping req before gnt withdraws the request; no error.
- Reset during ACCESS: the memory write in that cycle's low half still occurs. No rvalid is issued, and all outputs are 0 after the edge.
- mem_addr and mem_wdata return to 0 in IDLE and DONE.

Optional Feature:
- Macro: DMEM_ARB_PERF_EN.
- Defined:
  - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each), incremented on gnt0/gnt1.
  - Adds output conflict_cnt (16 bits), incremented in any arbitration cycle where both req are high.
  - All three saturate at 16'hFFFF and clear on reset.
- Not defined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package dmem_pkg:
  - state enum {IDLE, ACCESS, DONE}
  - DW, AW, DEPTH defaults
  - port id constants PORT_CPU = 0, PORT_DMA = 1
- One sub-module, rr_arb2: two-input round-robin picker holding last_grant. Inputs: req[1:0] and advance; outputs: one-hot grant.
- The remainder (FSM, command registers, response steering) stays in dmem_arbiter.

Test Plan:
- Write then read, port 0 only:
  - req0, we0=1, addr0=16'h0005, wdata0=16'hBEEF → gnt0 at N, mem_write=1 with mem_addr=5 at N+1, rvalid0 at N+2, err0=0.
  - Read of addr 5 → rdata0 = 16'hBEEF at rvalid.
- Simultaneous requests from reset: req0 and req1 both reads, held high → grants in order port 0, 1, 0, 1 on successive DONE/IDLE cycles.
- Out of range: port 1 read of addr 16'h0400 → mem_read stays 0 throughout; rvalid1=1, err1=1, rdata1=16'h0000.
- Back-to-back: req0 held for 3 reads → gnt0 at N, N+2, N+4; rvalid0 at N+2, N+4, N+6; busy stays high from N+1 to N+6.
- Reset mid-access: write of 16'h1234 to addr 7, reset_n=0 at the ACCESS closing edge → no rvalid, all outputs 0. A later read of addr 7 returns 16'h1234.
- With DMEM_ARB_PERF_EN: 4 simultaneous-request arbitrations → grant_cnt0 = 2, grant_cnt1 = 2, conflict_cnt = 4.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding,
// default geometry of the 16-bit data memory and requester port ids.
package dmem_pkg;

   localparam int DMEM_DW    = 16;
   localparam int DMEM_AW    = 16;
   localparam int DMEM_DEPTH = 1024;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DMA = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-input round-robin picker. Grant is combinational from req; the
// last winner is remembered only when the caller says the grant is taken.
module rr_arb2
   import dmem_pkg::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [1:0] req,
   input  logic       advance,
   output logic [1:0] grant
);

   logic last_grant;

   // Pick the lone requester, or on a tie the port that did not win last.
   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_grant == PORT_DMA) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Remember the winner; reset favours the CPU port on the first tie.
   always_ff @(posedge clk) begin
      if (!reset_n)
         last_grant <= PORT_DMA;
      else if (advance && (grant != 2'b00))
         last_grant <= grant[1];
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and access sequencer for the 16-bit data memory.
// Port 0 = CPU load/store, port 1 = loader/debug DMA. One access in flight:
// IDLE/DONE arbitrate, ACCESS drives the memory for one full cycle.
// Optional macro DMEM_ARB_PERF_EN adds saturating grant/conflict counters.
module dmem_arbiter
   import dmem_pkg::*;
#(
   parameter int DW    = DMEM_DW,
   parameter int AW    = DMEM_AW,
   parameter int DEPTH = DMEM_DEPTH
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          req0,
   input  logic          we0,
   input  logic [AW-1:0] addr0,
   input  logic [DW-1:0] wdata0,
   output logic          gnt0,
   output logic          rvalid0,
   output logic [DW-1:0] rdata0,
   output logic          err0,
   input  logic          req1,
   input  logic          we1,
   input  logic [AW-1:0] addr1,
   input  logic [DW-1:0] wdata1,
   output logic          gnt1,
   output logic          rvalid1,
   output logic [DW-1:0] rdata1,
   output logic          err1,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   output logic          mem_read,
   output logic          mem_write,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
`ifdef DMEM_ARB_PERF_EN
   ,
   output logic [15:0]   grant_cnt0,
   output logic [15:0]   grant_cnt1,
   output logic [15:0]   conflict_cnt
`endif
);

   state_t        state;
   logic          arb_en;
   logic [1:0]    arb_req;
   logic [1:0]    grant;
   logic          sel_we;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] sel_wdata;
   logic          sel_in_range;
   logic          cur_port;
   logic          cur_we;
   logic          cur_oor;

   // Arbitration only happens in IDLE or DONE, and never while reset is held.
   assign arb_en  = reset_n && ((state == IDLE) || (state == DONE));
   assign arb_req = arb_en ? {req1, req0} : 2'b00;
   assign gnt0    = grant[0];
   assign gnt1    = grant[1];
   assign busy    = (state != IDLE);

   rr_arb2 u_rr_arb2 (
      .clk     (clk),
      .reset_n (reset_n),
      .req     (arb_req),
      .advance (arb_en),
      .grant   (grant)
   );

   // Steer the winning port's command onto the latch inputs.
   always_comb begin
      sel_we    = we0;
      sel_addr  = addr0;
      sel_wdata = wdata0;
      if (grant[1]) begin
         sel_we    = we1;
         sel_addr  = addr1;
         sel_wdata = wdata1;
      end
      sel_in_range = (sel_addr < AW'(DEPTH));
   end

   // Sequencer: latch the command on grant, hold memory strobes for the
   // ACCESS cycle, then capture the response and pulse rvalid in DONE.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state     <= IDLE;
         cur_port  <= PORT_CPU;
         cur_we    <= 1'b0;
         cur_oor   <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         err0      <= 1'b0;
         err1      <= 1'b0;
         rdata0    <= '0;
         rdata1    <= '0;
      end else begin
         rvalid0   <= 1'b0;
         rvalid1   <= 1'b0;
         err0      <= 1'b0;
         err1      <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (grant != 2'b00) begin
                  state     <= ACCESS;
                  cur_port  <= grant[1];
                  cur_we    <= sel_we;
                  cur_oor   <= ~sel_in_range;
                  mem_addr  <= sel_addr;
                  mem_wdata <= sel_wdata;
                  mem_read  <= sel_in_range & ~sel_we;
                  mem_write <= sel_in_range & sel_we;
               end else begin
                  state <= IDLE;
               end
            end
            ACCESS: begin
               state <= DONE;
               if (cur_port == PORT_CPU) begin
                  rvalid0 <= 1'b1;
                  err0    <= cur_oor;
                  if (cur_oor)
                     rdata0 <= '0;
                  else if (!cur_we)
                     rdata0 <= mem_rdata;
               end else begin
                  rvalid1 <= 1'b1;
                  err1    <= cur_oor;
                  if (cur_oor)
                     rdata1 <= '0;
                  else if (!cur_we)
                     rdata1 <= mem_rdata;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DMEM_ARB_PERF_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Saturating counters of grants per port and of contended arbitrations.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         grant_cnt0   <= 16'd0;
         grant_cnt1   <= 16'd0;
         conflict_cnt <= 16'd0;
      end else begin
         if (grant[0])
            grant_cnt0 <= sat_inc16(grant_cnt0);
         if (grant[1])
            grant_cnt1 <= sat_inc16(grant_cnt1);
         if (arb_en && req0 && req1)
            conflict_cnt <= sat_inc16(conflict_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural data memory and a
// response scoreboard. Build with DMEM_ARB_PERF_EN to also check counters.
module tb_dmem_arbiter;

   logic        clk;
   logic        reset_n;
   logic        req0, we0, req1, we1;
   logic [15:0] addr0, wdata0, addr1, wdata1;
   logic        gnt0, rvalid0, err0, gnt1, rvalid1, err1;
   logic [15:0] rdata0, rdata1;
   logic [15:0] mem_addr, mem_wdata, mem_rdata;
   logic        mem_read, mem_write, busy;
`ifdef DMEM_ARB_PERF_EN
   logic [15:0] grant_cnt0, grant_cnt1, conflict_cnt;
`endif

   typedef struct {
      logic        port;
      logic [15:0] rdata;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] mem     [0:1023];
   logic [15:0] ref_mem [0:1023];
   logic [15:0] ref_rdata [0:1];
   int          tests = 0;
   int          fails = 0;

   dmem_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .req0      (req0),
      .we0       (we0),
      .addr0     (addr0),
      .wdata0    (wdata0),
      .gnt0      (gnt0),
      .rvalid0   (rvalid0),
      .rdata0    (rdata0),
      .err0      (err0),
      .req1      (req1),
      .we1       (we1),
      .addr1     (addr1),
      .wdata1    (wdata1),
      .gnt1      (gnt1),
      .rvalid1   (rvalid1),
      .rdata1    (rdata1),
      .err1      (err1),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_rdata (mem_rdata),
      .busy      (busy)
`ifdef DMEM_ARB_PERF_EN
      ,
      .grant_cnt0   (grant_cnt0),
      .grant_cnt1   (grant_cnt1),
      .conflict_cnt (conflict_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural memory: write on the clk-low half, combinational read.
   always @(negedge clk)
      if (mem_write) mem[mem_addr[9:0]] <= mem_wdata;
   assign mem_rdata = mem[mem_addr[9:0]];

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Predict the response for an access and push it on the scoreboard.
   task automatic push_exp(input logic port, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata);
      exp_t e;
      e.port = port;
      if (addr >= 16'd1024) begin
         e.rdata = 16'h0000;
         e.err   = 1'b1;
         ref_rdata[port] = 16'h0000;
      end else if (we) begin
         ref_mem[addr[9:0]] = wdata;
         e.rdata = ref_rdata[port];
         e.err   = 1'b0;
      end else begin
         e.rdata = ref_mem[addr[9:0]];
         e.err   = 1'b0;
         ref_rdata[port] = e.rdata;
      end
      exp_q.push_back(e);
   endtask

   // Scoreboard: every rvalid pops and checks the oldest expected response.
   always @(negedge clk) begin
      if (reset_n && (rvalid0 || rvalid1)) begin
         if (rvalid0 && rvalid1)
            check("rvalid_both", 32'(2'b11), 32'(2'b01));
         else if (exp_q.size() == 0)
            check("rvalid_spurious", 32'(1), 32'(0));
         else begin
            exp_t e;
            e = exp_q.pop_front();
            check("sb_port", 32'(rvalid1), 32'(e.port));
            check("sb_rdata", 32'(rvalid1 ? rdata1 : rdata0), 32'(e.rdata));
            check("sb_err", 32'(rvalid1 ? err1 : err0), 32'(e.err));
         end
      end
   end

   // Drive one request, wait (bounded) for its grant, then drop req.
   task automatic issue(input logic port, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata);
      bit got = 0;
      @(posedge clk); #1;
      if (port) begin
         req1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata;
      end else begin
         req0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata;
      end
      push_exp(port, we, addr, wdata);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if ((port ? gnt1 : gnt0) === 1'b1) begin
            got = 1;
            break;
         end
      end
      if (!got) check("gnt_timeout", 32'(0), 32'(1));
      @(posedge clk); #1;
      if (port) req1 = 1'b0; else req0 = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 20; i++) begin
         if (exp_q.size() == 0) break;
         @(negedge clk);
      end
      check("drain_empty", 32'(exp_q.size()), 32'(0));
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_ctl"}, 32'({gnt0, gnt1, rvalid0, rvalid1, err0, err1,
                                mem_read, mem_write, busy}), 32'(0));
      check({tag, "_rdata"}, {rdata1, rdata0}, 32'(0));
      check({tag, "_mem"}, {mem_addr, mem_wdata}, 32'(0));
   endtask

   initial begin
      for (int i = 0; i < 1024; i++) begin
         mem[i]     = 16'h0000;
         ref_mem[i] = 16'h0000;
      end
      ref_rdata[0] = 16'h0000;
      ref_rdata[1] = 16'h0000;
      reset_n = 1'b0;
      req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0000; wdata0 = 16'h0000;
      req1 = 1'b0; we1 = 1'b0; addr1 = 16'h0000; wdata1 = 16'h0000;

      // Reset state
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      reset_n = 1'b1;

      // Port 0 write with cycle-exact timing
      @(posedge clk); #1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0005; wdata0 = 16'hBEEF;
      push_exp(1'b0, 1'b1, 16'h0005, 16'hBEEF);
      @(negedge clk);
      check("wr_gnt0_N", 32'({gnt0, gnt1, busy}), 32'(3'b100));
      @(posedge clk); #1;
      req0 = 1'b0;
      @(negedge clk);
      check("wr_access_ctl", 32'({mem_write, mem_read, busy, gnt0}), 32'(4'b1010));
      check("wr_access_bus", {mem_addr, mem_wdata}, {16'h0005, 16'hBEEF});
      @(negedge clk);
      check("wr_rvalid0_N2", 32'({rvalid0, mem_write, busy}), 32'(3'b101));
      check("wr_done_addr", 32'(mem_addr), 32'(0));
      drain();

      // Port 0 read back
      issue(1'b0, 1'b0, 16'h0005, 16'h0000);
      drain();

      // Simultaneous reads from reset: strict alternation 0,1,0,1
      @(posedge clk); #1;
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      ref_rdata[0] = 16'h0000;
      ref_rdata[1] = 16'h0000;
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0005;
      push_exp(1'b0, 1'b0, 16'h0005, 16'h0000);
      push_exp(1'b1, 1'b0, 16'h0005, 16'h0000);
      push_exp(1'b0, 1'b0, 16'h0005, 16'h0000);
      push_exp(1'b1, 1'b0, 16'h0005, 16'h0000);
      for (int c = 0; c < 9; c++) begin
         @(negedge clk);
         check($sformatf("rr_gnt_c%0d", c), 32'({gnt0, gnt1}),
               32'({(c == 0 || c == 4), (c == 2 || c == 6)}));
         @(posedge clk); #1;
         if (c == 6) begin
            req0 = 1'b0;
            req1 = 1'b0;
         end
      end
      drain();
`ifdef DMEM_ARB_PERF_EN
      check("perf_grant_cnt0", 32'(grant_cnt0), 32'(2));
      check("perf_grant_cnt1", 32'(grant_cnt1), 32'(2));
      check("perf_conflict_cnt", 32'(conflict_cnt), 32'(4));
`endif

      // Out of range read on port 1: no memory strobe, err with zero data
      issue(1'b1, 1'b0, 16'h0400, 16'h0000);
      @(negedge clk);
      check("oor_access", 32'({mem_read, mem_write, busy}), 32'(3'b001));
      @(negedge clk);
      check("oor_done", 32'({mem_read, mem_write, rvalid1}), 32'(3'b001));
      drain();

      // Port 1 write and read
      issue(1'b1, 1'b1, 16'h000A, 16'h5A5A);
      drain();
      issue(1'b1, 1'b0, 16'h000A, 16'h0000);
      drain();

      // Back-to-back reads on port 0 with req held, last at DEPTH-1
      @(posedge clk); #1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0005;
      push_exp(1'b0, 1'b0, 16'h0005, 16'h0000);
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         check($sformatf("b2b_c%0d", c), 32'({gnt0, rvalid0, busy}),
               32'({(c == 0 || c == 2 || c == 4), (c == 2 || c == 4 || c == 6),
                    (c >= 1 && c <= 6)}));
         if (c == 1 || c == 3 || c == 5)
            check($sformatf("b2b_mem_c%0d", c), {mem_addr, 15'd0, mem_read},
                  {(c == 1) ? 16'h0005 : (c == 3) ? 16'h000A : 16'h03FF, 16'h0001});
         @(posedge clk); #1;
         if (c == 0) begin
            addr0 = 16'h000A;
            push_exp(1'b0, 1'b0, 16'h000A, 16'h0000);
         end else if (c == 2) begin
            addr0 = 16'h03FF;
            push_exp(1'b0, 1'b0, 16'h03FF, 16'h0000);
         end else if (c == 4) begin
            req0 = 1'b0;
         end
      end
      drain();

      // Reset at the closing edge of a write ACCESS
      @(posedge clk); #1;
      req0 = 1'b1; we0 = 1'b1; addr0 = 16'h0007; wdata0 = 16'h1234;
      @(negedge clk);
      check("rst_mid_gnt0", 32'(gnt0), 32'(1));
      @(posedge clk); #1;
      req0 = 1'b0; we0 = 1'b0;
      reset_n = 1'b0;
      @(negedge clk);
      check("rst_mid_access", {mem_addr, 15'd0, mem_write}, {16'h0007, 16'h0001});
      @(posedge clk); #1;
      reset_n = 1'b1;
      ref_mem[7]   = 16'h1234;
      ref_rdata[0] = 16'h0000;
      ref_rdata[1] = 16'h0000;
      @(negedge clk);
      check_all_zero("rst_mid_after");
`ifdef DMEM_ARB_PERF_EN
      check("perf_cleared", {grant_cnt0, grant_cnt1 | conflict_cnt}, 32'(0));
`endif
      @(negedge clk);
      check("rst_mid_no_rvalid", 32'({rvalid0, rvalid1}), 32'(0));
      issue(1'b1, 1'b0, 16'h0007, 16'h0000);
      drain();

      repeat (2) @(posedge clk);
      check("final_queue", 32'(exp_q.size()), 32'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
